ws2812b_encoder: RTL

Serial WS2812B transmitter: accepts 24-bit pixels ({G,R,B}) over a valid/ready handshake and drives the single-wire NRZ waveform that the impostor peripheral's pulse decoder consumes, followed by a latch (reset) gap on request. It sits directly upstream of the impostor on the LED chain. In a test system, its `dout` drives the impostor's `ui_in[1]`. Timing defaults target a 64 MHz clock and match the decoder threshold (38 cycles) and idle detector (60 µs).

---
 rtl/ws2812b_encoder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ws2812b_encoder.sv
// WS2812B single-wire NRZ transmitter: 24-bit {G,R,B} pixels in over valid/ready,
// serialized MSB first, with an optional latch gap that ends in a frame_done pulse.
//
// state | meaning
// IDLE  | line low, waiting for a pixel or a latch request
// HIGH  | dout high for T0H/T1H of the current bit
// LOW   | dout low for the rest of the bit period
// GAP   | dout low for RESET_CYCLES (latch), then frame_done
module ws2812b_encoder #(
  parameter int CLK_HZ       = 64000000,
  parameter int T0H_CYCLES   = 26,
  parameter int T1H_CYCLES   = 51,
  parameter int BIT_CYCLES   = 80,
  parameter int RESET_CYCLES = 3840
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  input  logic        latch,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CW = $clog2(RESET_CYCLES);
  localparam logic [CW-1:0] T0H_M1 = CW'(T0H_CYCLES - 1);
  localparam logic [CW-1:0] T1H_M1 = CW'(T1H_CYCLES - 1);
  localparam logic [CW-1:0] LOW0_M1 = CW'(BIT_CYCLES - T0H_CYCLES - 1);
  localparam logic [CW-1:0] LOW1_M1 = CW'(BIT_CYCLES - T1H_CYCLES - 1);
  localparam logic [CW-1:0] GAP_M1 = CW'(RESET_CYCLES - 1);

  if (CLK_HZ <= 0 || T0H_CYCLES <= 0 || T1H_CYCLES <= T0H_CYCLES ||
      BIT_CYCLES <= T1H_CYCLES || RESET_CYCLES <= BIT_CYCLES) begin : g_param_check
    $error("ws2812b_encoder: invalid timing parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t        state, state_nxt;
  logic [23:0]   shift_q, shift_nxt;
  logic [4:0]    idx_q, idx_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          pend_q, pend_nxt;
  logic          rdy_en_q;
  logic          dout_d, busy_d, frame_done_d;
  logic          accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_q    <= shift_nxt;
      idx_q      <= idx_nxt;
      cnt_q      <= cnt_nxt;
      pend_q     <= pend_nxt;
      rdy_en_q   <= 1'b1;
      dout       <= dout_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  assign accept = pixel_valid && pixel_ready;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    idx_nxt   = idx_q;
    cnt_nxt   = cnt_q;
    pend_nxt  = pend_q;
    unique case (state)
      S_IDLE: begin
        if (latch || pend_q) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_M1;
          pend_nxt  = 1'b0;
        end else if (accept) begin
          state_nxt = S_HIGH;
          shift_nxt = pixel_data;
          idx_nxt   = 5'd23;
          cnt_nxt   = pixel_data[23] ? T1H_M1 : T0H_M1;
        end
      end
      S_HIGH: begin
        pend_nxt = pend_q | latch;
        if (cnt_q == '0) begin
          state_nxt = S_LOW;
          cnt_nxt   = shift_q[23] ? LOW1_M1 : LOW0_M1;
        end else begin
          cnt_nxt = cnt_q - CW'(1);
        end
      end
      S_LOW: begin
        pend_nxt = pend_q | latch;
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - CW'(1);
        end else if (idx_q != 5'd0) begin
          state_nxt = S_HIGH;
          shift_nxt = {shift_q[22:0], 1'b0};
          idx_nxt   = idx_q - 5'd1;
          cnt_nxt   = shift_q[22] ? T1H_M1 : T0H_M1;
        end else if (pend_q) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_M1;
          pend_nxt  = 1'b0;
        end else if (accept) begin
          state_nxt = S_HIGH;
          shift_nxt = pixel_data;
          idx_nxt   = 5'd23;
          cnt_nxt   = pixel_data[23] ? T1H_M1 : T0H_M1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) state_nxt = S_IDLE;
        else             cnt_nxt   = cnt_q - CW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    pixel_ready  = rdy_en_q && !pend_q &&
                   ((state == S_IDLE && !latch) ||
                    (state == S_LOW && cnt_q == '0 && idx_q == 5'd0));
    dout_d       = (state_nxt == S_HIGH);
    busy_d       = (state_nxt != S_IDLE);
    frame_done_d = (state_nxt == S_GAP) && (cnt_nxt == '0);
  end

endmodule
